wb_slave_rx: RTL and testbench

WB_SLAVE_RX -- requirements
Module: wb_slave_rx

---
 rtl/wb_slave_rx_pkg.sv | 23 ++
 rtl/wb_slave_rx_fifo.sv | 48 ++++
 rtl/wb_slave_rx.sv | 109 ++++++++++
 tb/tb_wb_slave_rx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_slave_rx_pkg.sv
// wb_slave_rx_pkg: shared bus widths, CTI codes, FSM encoding and buffer entry type
// Imported by wb_slave_rx and nic_chunk_fifo.
package wb_slave_rx_pkg;
    localparam int BUS_ADDRESS_WIDTH = 32;
    localparam int BUS_DATA_WIDTH = 32;
    localparam int GRANULARITY = 8;
    localparam int SEL_WIDTH = BUS_DATA_WIDTH / GRANULARITY;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST = 3'b001;
    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_END = 3'b111;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RECEIVE = 2'b01,
        HOLD = 2'b10
    } state_t;
    typedef struct packed {
        logic we;
        logic [SEL_WIDTH-1:0] sel;
        logic [BUS_ADDRESS_WIDTH-1:0] adr;
        logic [BUS_DATA_WIDTH-1:0] dat;
    } chunk_t;
endpackage

// File: rtl/wb_slave_rx_fifo.sv
// nic_chunk_fifo: chunk buffer with push/pop/flush, full/empty flags and occupancy
// Ports: clk, rst (async, active-low); push/din write an entry; pop removes the head;
// flush empties the buffer; head is the oldest entry (zero when empty); full, empty, level.
module nic_chunk_fifo
    import wb_slave_rx_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic                flush,
    input  chunk_t              din,
    output chunk_t              head,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] level
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    chunk_t mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = level[DEPTH_LOG2];
    assign empty = level == '0;
    // A full buffer refuses a push even when the head is popped in the same cycle.
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign head = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
        end else begin
            wr_ptr <= wr_ptr + DEPTH_LOG2'(do_push);
            rd_ptr <= rd_ptr + DEPTH_LOG2'(do_pop);
            level <= level + (DEPTH_LOG2 + 1)'(do_push) - (DEPTH_LOG2 + 1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/wb_slave_rx.sv
// wb_slave_rx: WISHBONE slave that collects one bus cycle into a chunk buffer and holds it
// Ports: clk, rst (async, active-low); WISHBONE slave CYC_I/STB_I/WE_I/ADR_I/DAT_I/SEL_I/CTI_I
// in, ACK_O/STALL_O/RTY_O/ERR_O out; chunk_* head-of-buffer view with chunk_pop_i;
// message_ready_o/burst_lenght_o/performing_read_o describe the held cycle, released by
// message_consumed_i. Define NIC_RTY_ON_BUSY_EN to answer strobes during HOLD with RTY_O
// instead of stalling them.
module wb_slave_rx
    import wb_slave_rx_pkg::*;
#(
    parameter int N_BITS_BURST_LENGHT = 7,
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           CYC_I,
    input  logic                           STB_I,
    input  logic                           WE_I,
    input  logic [BUS_ADDRESS_WIDTH-1:0]   ADR_I,
    input  logic [BUS_DATA_WIDTH-1:0]      DAT_I,
    input  logic [SEL_WIDTH-1:0]           SEL_I,
    input  logic [2:0]                     CTI_I,
    output logic                           ACK_O,
    output logic                           STALL_O,
    output logic                           RTY_O,
    output logic                           ERR_O,
    output logic                           chunk_valid_o,
    output logic [BUS_ADDRESS_WIDTH-1:0]   chunk_address_o,
    output logic [BUS_DATA_WIDTH-1:0]      chunk_data_o,
    output logic [SEL_WIDTH-1:0]           chunk_sel_o,
    output logic                           chunk_we_o,
    input  logic                           chunk_pop_i,
    output logic                           message_ready_o,
    output logic [N_BITS_BURST_LENGHT-1:0] burst_lenght_o,
    input  logic                           message_consumed_i,
    output logic                           performing_read_o
);
`ifdef NIC_RTY_ON_BUSY_EN
    localparam logic HOLD_STALL = 1'b0;
`else
    localparam logic HOLD_STALL = 1'b1;
`endif
    state_t state, state_next;
    logic [N_BITS_BURST_LENGHT-1:0] count;
    logic cycle_we, full, empty, req, accept, good, bad, rty_hit, flush;
    logic [FIFO_DEPTH_LOG2:0] level;
    logic unused;
    chunk_t head;
    assign unused = ^{CTI_I, level};
    assign req = CYC_I && STB_I;
    assign accept = req && !STALL_O && (state == IDLE || state == RECEIVE);
    // The first strobe defines the cycle type; later ones must match it and fit the counter.
    assign good = accept && (state == IDLE || (WE_I == cycle_we && count != '1));
    assign bad = accept && !good;
    assign rty_hit = state == HOLD && req && !HOLD_STALL;
    assign flush = state == HOLD && message_consumed_i;
    assign burst_lenght_o = count;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_next;
    end
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE: state_next = good ? RECEIVE : IDLE;
            RECEIVE: state_next = CYC_I ? RECEIVE : HOLD;
            HOLD: state_next = message_consumed_i ? IDLE : HOLD;
            default: state_next = IDLE;
        endcase
    end
    always_comb begin
        STALL_O = state == HOLD ? HOLD_STALL : full;
        message_ready_o = state == HOLD;
        performing_read_o = state == HOLD && !cycle_we;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ACK_O <= 1'b0;
            ERR_O <= 1'b0;
            RTY_O <= 1'b0;
            count <= '0;
            cycle_we <= 1'b0;
        end else begin
            // Reads are answered by the master path, so only accepted writes are acked here.
            ACK_O <= good && WE_I;
            ERR_O <= bad;
            RTY_O <= rty_hit;
            if (flush) count <= '0;
            else if (good) count <= count + N_BITS_BURST_LENGHT'(1);
            if (state == IDLE && good) cycle_we <= WE_I;
        end
    end
    nic_chunk_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (good),
        .pop  (chunk_pop_i),
        .flush(flush),
        .din  ('{we: WE_I, sel: SEL_I, adr: ADR_I, dat: DAT_I}),
        .head (head),
        .full (full),
        .empty(empty),
        .level(level)
    );
    assign chunk_valid_o = !empty;
    assign chunk_we_o = head.we;
    assign chunk_sel_o = head.sel;
    assign chunk_address_o = head.adr;
    assign chunk_data_o = head.dat;
endmodule

// File: tb/tb_wb_slave_rx.sv
// tb_wb_slave_rx: directed table-driven bench for wb_slave_rx plus multi-cycle corner sequences
module tb_wb_slave_rx;
`ifdef NIC_RTY_ON_BUSY_EN
    localparam logic HS = 1'b0;
`else
    localparam logic HS = 1'b1;
`endif
    logic clk = 1'b0, rst = 1'b0;
    logic cyc = 0, stb = 0, we = 0, pop = 0, cons = 0;
    logic [31:0] adr = 0, dat = 0;
    logic [3:0] sel = 4'hf;
    logic [2:0] cti = 3'b000;
    logic ack, stall, rty, err, valid, cwe, ready, rd;
    logic [31:0] cadr, cdat;
    logic [3:0] csel;
    logic [6:0] burst;
    int n_chk = 0, n_fail = 0, acks;

    wb_slave_rx dut (
        .clk(clk), .rst(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we), .ADR_I(adr), .DAT_I(dat),
        .SEL_I(sel), .CTI_I(cti), .ACK_O(ack), .STALL_O(stall), .RTY_O(rty), .ERR_O(err),
        .chunk_valid_o(valid), .chunk_address_o(cadr), .chunk_data_o(cdat), .chunk_sel_o(csel),
        .chunk_we_o(cwe), .chunk_pop_i(pop), .message_ready_o(ready), .burst_lenght_o(burst),
        .message_consumed_i(cons), .performing_read_o(rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("resp_onehot", {31'd0, $onehot0({ack, err, rty})}, 1);
    endtask

    typedef struct {
        logic cyc, stb, we, pop, cons;
        logic [31:0] dat;
        logic ack, err, stall, ready, rd, valid;
        logic [6:0] burst;
        logic [31:0] head;
    } vec_t;
    vec_t tab[10];

    initial begin
        tab[0] = '{0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 7'd0, 32'h0};
        tab[1] = '{1, 1, 1, 0, 0, 32'hA5A5A5A5, 1, 0, 0, 0, 0, 1, 7'd1, 32'hA5A5A5A5};
        tab[2] = '{0, 0, 0, 0, 0, 32'h0, 0, 0, HS, 1, 0, 1, 7'd1, 32'hA5A5A5A5};
        tab[3] = '{0, 0, 0, 0, 1, 32'h0, 0, 0, 0, 0, 0, 0, 7'd0, 32'h0};
        tab[4] = '{1, 1, 1, 0, 0, 32'h1, 1, 0, 0, 0, 0, 1, 7'd1, 32'h1};
        tab[5] = '{1, 1, 1, 0, 0, 32'h2, 1, 0, 0, 0, 0, 1, 7'd2, 32'h1};
        tab[6] = '{1, 1, 0, 0, 0, 32'h3, 0, 1, 0, 0, 0, 1, 7'd2, 32'h1};
        tab[7] = '{0, 0, 0, 0, 0, 32'h0, 0, 0, HS, 1, 0, 1, 7'd2, 32'h1};
        tab[8] = '{0, 0, 0, 1, 0, 32'h0, 0, 0, HS, 1, 0, 1, 7'd2, 32'h2};
        tab[9] = '{0, 0, 0, 1, 1, 32'h0, 0, 0, 0, 0, 0, 0, 7'd0, 32'h0};

        #2;
        chk("rst_ack", ack, 0); chk("rst_stall", stall, 0); chk("rst_err", err, 0);
        chk("rst_rty", rty, 0); chk("rst_valid", valid, 0); chk("rst_ready", ready, 0);
        chk("rst_rd", rd, 0); chk("rst_burst", burst, 0);
        #10 rst = 1'b1;
        adr = 32'h10;

        // table: single write, then a write cycle with WE toggled on the third strobe
        for (int i = 0; i < 10; i++) begin
            cyc = tab[i].cyc; stb = tab[i].stb; we = tab[i].we; pop = tab[i].pop;
            cons = tab[i].cons; dat = tab[i].dat;
            step();
            chk($sformatf("t%0d_ack", i), ack, tab[i].ack);
            chk($sformatf("t%0d_err", i), err, tab[i].err);
            chk($sformatf("t%0d_stall", i), stall, tab[i].stall);
            chk($sformatf("t%0d_ready", i), ready, tab[i].ready);
            chk($sformatf("t%0d_rd", i), rd, tab[i].rd);
            chk($sformatf("t%0d_valid", i), valid, tab[i].valid);
            chk($sformatf("t%0d_burst", i), burst, tab[i].burst);
            chk($sformatf("t%0d_head", i), cdat, tab[i].head);
        end
        pop = 0; cons = 0;

        // ten pipelined writes into an eight-entry buffer
        cyc = 1; stb = 1; we = 1;
        for (int i = 0; i < 8; i++) begin
            dat = i;
            step();
            chk("b10_ack", ack, 1);
        end
        chk("b10_full_stall", stall, 1);
        dat = 8;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("b10_blocked_ack", ack, 0);
            chk("b10_blocked_stall", stall, 1);
        end
        pop = 1;
        step();
        chk("b10_pop_full_ack", ack, 0);
        chk("b10_pop_full_stall", stall, 0);
        step();
        chk("b10_push_pop_ack", ack, 1);
        chk("b10_push_pop_stall", stall, 0);
        pop = 0; dat = 9;
        step();
        chk("b10_last_ack", ack, 1);
        chk("b10_last_stall", stall, 1);
        cyc = 0; stb = 0;
        step();
        chk("b10_ready", ready, 1);
        chk("b10_burst", burst, 10);
        for (int k = 2; k < 10; k++) begin
            chk("b10_head", cdat, k);
            pop = 1;
            step();
            pop = 0;
        end
        chk("b10_drained", valid, 0);
        cons = 1;
        step();
        cons = 0;

        // read burst of four
        cyc = 1; stb = 1; we = 0;
        for (int i = 0; i < 4; i++) begin
            adr = 32'h100 + i;
            step();
            chk("rd_no_ack", ack, 0);
        end
        cyc = 0; stb = 0;
        step();
        chk("rd_perf", rd, 1);
        chk("rd_ready", ready, 1);
        chk("rd_burst", burst, 4);
        for (int i = 0; i < 4; i++) begin
            chk("rd_valid", valid, 1);
            chk("rd_we", cwe, 0);
            chk("rd_adr", cadr, 32'h100 + i);
            pop = 1;
            step();
            pop = 0;
        end
        cons = 1;
        step();
        cons = 0;
        chk("rd_idle_perf", rd, 0);

        // new cycle while a message is held
        cyc = 1; stb = 1; we = 1; dat = 32'h55;
        step();
        cyc = 0; stb = 0;
        step();
        chk("busy_ready", ready, 1);
        cyc = 1; stb = 1; dat = 32'hBB;
        for (int i = 0; i < 2; i++) begin
            chk("busy_stall", stall, HS);
            step();
            chk("busy_rty", rty, !HS);
            chk("busy_ack", ack, 0);
            chk("busy_burst", burst, 1);
            chk("busy_head", cdat, 32'h55);
        end
        cyc = 0; stb = 0; cons = 1;
        step();
        cons = 0;
        chk("busy_idle_ready", ready, 0);
        chk("busy_idle_stall", stall, 0);
        chk("busy_idle_valid", valid, 0);

        // strobe counter limit with streaming pops
        cyc = 1; stb = 1; we = 1; pop = 1; acks = 0;
        for (int i = 0; i < 127; i++) begin
            dat = i;
            step();
            acks += int'(ack);
        end
        chk("ovf_acks", acks, 127);
        chk("ovf_burst_max", burst, 127);
        step();
        chk("ovf_err", err, 1);
        chk("ovf_ack", ack, 0);
        chk("ovf_burst", burst, 127);
        cyc = 0; stb = 0; pop = 0;
        step();
        chk("ovf_ready", ready, 1);
        chk("ovf_burst_held", burst, 127);
        cons = 1;
        step();
        cons = 0;

        // reset during strobe 3 of 5
        cyc = 1; stb = 1; we = 1;
        for (int i = 1; i <= 2; i++) begin
            dat = i;
            step();
        end
        chk("mr_pre_ack", ack, 1);
        dat = 3;
        #2 rst = 0;
        #1;
        chk("mr_ack", ack, 0); chk("mr_stall", stall, 0); chk("mr_err", err, 0);
        chk("mr_rty", rty, 0); chk("mr_valid", valid, 0); chk("mr_ready", ready, 0);
        chk("mr_rd", rd, 0); chk("mr_burst", burst, 0); chk("mr_data", cdat, 0);
        step();
        chk("mr_held_ack", ack, 0);
        cyc = 0; stb = 0;
        rst = 1;
        step();
        chk("mr_rel_valid", valid, 0);
        chk("mr_rel_ready", ready, 0);
        cyc = 1; stb = 1; dat = 32'h77;
        step();
        chk("mr_new_ack", ack, 1);
        chk("mr_new_burst", burst, 1);
        chk("mr_new_head", cdat, 32'h77);
        cyc = 0; stb = 0;
        step();
        chk("mr_new_ready", ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
